// File: rtl/arbitro_rom.sv
// Glyph ROM arbiter: shares one ROM slot per cycle between a display fetch port
// and an auxiliary fetch port, with starvation protection for the aux side.
module arbitro_rom #(
  parameter int STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       disp_req,
  input  logic [2:0] disp_en,
  input  logic [3:0] disp_py,
  input  logic       aux_req,
  input  logic [2:0] aux_en,
  input  logic [3:0] aux_py,
  input  logic [7:0] rom_data,
  output logic [2:0] rom_en,
  output logic [3:0] rom_py,
  output logic [7:0] disp_data,
  output logic       disp_valid,
  output logic       aux_gnt,
  output logic [7:0] aux_data,
  output logic       aux_valid,
  output logic [7:0] disp_miss_cnt
);

  // state | meaning
  // IDLE  | slot just granted to nobody; ROM address parked at 0
  // DISP  | slot just granted to display; its row is on rom_data now
  // AUX   | slot just granted to aux; its row is on rom_data now
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    AUX  = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t     state;
  owner_t     grant;
  logic       outstanding;
  logic       aux_pending;
  logic [3:0] starve_cnt;
  logic [2:0] next_en;
  logic [3:0] next_py;

  // A held aux_req must not be granted twice: outstanding covers gnt..valid.
  always_comb begin
    aux_pending = aux_req && !outstanding;
    grant       = IDLE;
    if (aux_pending && (starve_cnt == STARVE_LIM)) begin
      grant = AUX;
    end else if (disp_req) begin
      grant = DISP;
    end else if (aux_pending) begin
      grant = AUX;
    end
  end

  always_comb begin
    next_en = 3'd0;
    next_py = 4'd0;
    case (grant)
      DISP: begin
        next_en = disp_en;
        next_py = disp_py;
      end
      AUX: begin
        next_en = aux_en;
        next_py = aux_py;
      end
      default: begin
        next_en = 3'd0;
        next_py = 4'd0;
      end
    endcase
  end

  assign aux_gnt = (grant == AUX) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rom_en <= 3'd0;
      rom_py <= 4'd0;
    end else begin
      state  <= grant;
      rom_en <= next_en;
      rom_py <= next_py;
    end
  end

  // rom_data reflects the address granted last cycle, tagged by state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_data  <= 8'd0;
      disp_valid <= 1'b0;
      aux_data   <= 8'd0;
      aux_valid  <= 1'b0;
    end else begin
      disp_valid <= (state == DISP);
      aux_valid  <= (state == AUX);
      if (state == DISP) begin
        disp_data <= rom_data;
      end
      if (state == AUX) begin
        aux_data <= rom_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= 1'b0;
    end else if (grant == AUX) begin
      outstanding <= 1'b1;
    end else if (aux_valid) begin
      outstanding <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if ((grant == AUX) || !aux_pending) begin
      starve_cnt <= 4'd0;
    end else if ((grant == DISP) && (starve_cnt < STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // A display request losing the slot to aux is dropped, not queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_miss_cnt <= 8'd0;
    end else if (disp_req && (grant == AUX) && (disp_miss_cnt != 8'hFF)) begin
      disp_miss_cnt <= disp_miss_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_arbitro_rom.sv
// Self-checking bench for arbitro_rom: vector table for the basic pipeline,
// plus sequences for starvation, miss saturation, reset abort and random traffic.
module tb_arbitro_rom;

  logic       clk = 1'b0;
  logic       reset;
  logic       disp_req;
  logic [2:0] disp_en;
  logic [3:0] disp_py;
  logic       aux_req;
  logic [2:0] aux_en;
  logic [3:0] aux_py;
  logic [7:0] rom_data;
  logic [2:0] rom_en;
  logic [3:0] rom_py;
  logic [7:0] disp_data;
  logic       disp_valid;
  logic       aux_gnt;
  logic [7:0] aux_data;
  logic       aux_valid;
  logic [7:0] disp_miss_cnt;

  int total = 0;
  int bad   = 0;

  arbitro_rom #(.STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_en(disp_en), .disp_py(disp_py),
    .aux_req(aux_req), .aux_en(aux_en), .aux_py(aux_py),
    .rom_data(rom_data), .rom_en(rom_en), .rom_py(rom_py),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .aux_gnt(aux_gnt), .aux_data(aux_data), .aux_valid(aux_valid),
    .disp_miss_cnt(disp_miss_cnt)
  );

  always #5 clk = ~clk;

  // Glyph ROM model: blank for glyph 0, one special row, else {0,en,py}.
  always_comb begin
    if (rom_en == 3'd0)                       rom_data = 8'h00;
    else if (rom_en == 3'd3 && rom_py == 4'd5) rom_data = 8'hA5;
    else                                      rom_data = {1'b0, rom_en, rom_py};
  end

  typedef struct {
    logic       dr;
    logic [2:0] de;
    logic [3:0] dp;
    logic       ar;
    logic [2:0] ae;
    logic [3:0] ap;
    logic       gnt;
    logic [2:0] ren;
    logic [3:0] rpy;
    logic       dv;
    logic [7:0] dd;
    logic       av;
    logic [7:0] ad;
  } vec_t;

  vec_t vec [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req = 1'b0; disp_en = 3'd0; disp_py = 4'd0;
    aux_req  = 1'b0; aux_en  = 3'd0; aux_py  = 4'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cyc;
    int reqs, dvs, gnts, avs, both;

    vec[0]  = '{0,0,0, 0,0,0,  0,0,0,  0,8'h00, 0,8'h00};
    vec[1]  = '{1,3,5, 0,0,0,  0,0,0,  0,8'h00, 0,8'h00};
    vec[2]  = '{0,0,0, 0,0,0,  0,3,5,  0,8'h00, 0,8'h00};
    vec[3]  = '{0,0,0, 0,0,0,  0,0,0,  1,8'hA5, 0,8'h00};
    vec[4]  = '{0,0,0, 1,6,15, 1,0,0,  0,8'hA5, 0,8'h00};
    vec[5]  = '{0,0,0, 1,6,15, 0,6,15, 0,8'hA5, 0,8'h00};
    vec[6]  = '{0,0,0, 1,6,15, 0,0,0,  0,8'hA5, 1,8'h6F};
    vec[7]  = '{0,0,0, 0,0,0,  0,0,0,  0,8'hA5, 0,8'h6F};
    vec[8]  = '{1,1,2, 1,2,3,  0,0,0,  0,8'hA5, 0,8'h6F};
    vec[9]  = '{1,0,7, 1,2,3,  0,1,2,  0,8'hA5, 0,8'h6F};
    vec[10] = '{0,0,0, 1,2,3,  1,0,7,  1,8'h12, 0,8'h6F};
    vec[11] = '{1,4,1, 1,2,3,  0,2,3,  1,8'h00, 0,8'h6F};
    vec[12] = '{1,5,9, 0,0,0,  0,4,1,  0,8'h00, 1,8'h23};
    vec[13] = '{0,0,0, 0,0,0,  0,5,9,  1,8'h41, 0,8'h23};
    vec[14] = '{0,0,0, 0,0,0,  0,0,0,  1,8'h59, 0,8'h23};
    vec[15] = '{0,0,0, 0,0,0,  0,0,0,  0,8'h59, 0,8'h23};

    // Table: registered outputs checked at cycle start, aux_gnt after inputs settle.
    reset = 1'b1;
    idle_inputs();
    #1;
    check("rst_aux_gnt", aux_gnt, 0);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("v%0d_rom_en", i), rom_en, vec[i].ren);
      check($sformatf("v%0d_rom_py", i), rom_py, vec[i].rpy);
      check($sformatf("v%0d_dvalid", i), disp_valid, vec[i].dv);
      check($sformatf("v%0d_ddata", i), disp_data, vec[i].dd);
      check($sformatf("v%0d_avalid", i), aux_valid, vec[i].av);
      check($sformatf("v%0d_adata", i), aux_data, vec[i].ad);
      check($sformatf("v%0d_miss", i), disp_miss_cnt, 0);
      disp_req = vec[i].dr; disp_en = vec[i].de; disp_py = vec[i].dp;
      aux_req  = vec[i].ar; aux_en  = vec[i].ae; aux_py  = vec[i].ap;
      #1;
      check($sformatf("v%0d_gnt", i), aux_gnt, vec[i].gnt);
      step();
    end

    // Starvation: continuous display traffic must yield after 8 grants.
    do_reset();
    disp_req = 1'b1; disp_en = 3'd2; disp_py = 4'd1;
    aux_req  = 1'b1; aux_en  = 3'd6; aux_py  = 4'd15;
    cyc = 0;
    #1;
    while (!aux_gnt && cyc < 40) begin
      step();
      cyc++;
      #1;
    end
    check("starve_gnt_cycle", cyc, 8);
    step();
    check("starve_miss", disp_miss_cnt, 1);
    step();
    check("starve_dv_gap", disp_valid, 0);
    check("starve_av", aux_valid, 1);
    check("starve_ad", aux_data, 8'h6F);
    step();
    check("starve_resume", disp_valid, 1);
    check("starve_resume_dd", disp_data, 8'h21);

    // Miss saturation: keep forcing starvation well past 255 drops.
    for (int i = 0; i < 3500; i++) step();
    check("miss_saturate", disp_miss_cnt, 255);

    // Reset in the cycle after aux_gnt aborts the fetch.
    do_reset();
    aux_req = 1'b1; aux_en = 3'd6; aux_py = 4'd15;
    #1;
    check("rst_pre_gnt", aux_gnt, 1);
    step();
    reset = 1'b1;
    #1;
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_py", rom_py, 0);
    check("rst_avalid", aux_valid, 0);
    check("rst_dvalid", disp_valid, 0);
    check("rst_adata", aux_data, 0);
    check("rst_gnt_held", aux_gnt, 0);
    step();
    check("rst_no_av", aux_valid, 0);
    reset = 1'b0;
    #1;
    check("rel_gnt", aux_gnt, 1);
    step();
    check("rel_no_av_n1", aux_valid, 0);
    check("rel_rom_en", rom_en, 6);
    step();
    check("rel_av", aux_valid, 1);
    check("rel_ad", aux_data, 8'h6F);

    // Random traffic: every display request ends as a valid or a miss.
    do_reset();
    reqs = 0; dvs = 0; gnts = 0; avs = 0; both = 0;
    for (int i = 0; i < 10000; i++) begin
      if (disp_valid) dvs++;
      if (aux_valid) avs++;
      if (disp_valid && aux_valid) both++;
      if (aux_valid) aux_req = 1'b0;
      else if (!aux_req && ($urandom_range(39) == 0)) begin
        aux_req = 1'b1;
        aux_en  = 3'($urandom_range(6));
        aux_py  = 4'($urandom_range(15));
      end
      disp_req = 1'($urandom_range(1));
      disp_en  = 3'($urandom_range(6));
      disp_py  = 4'($urandom_range(15));
      if (disp_req) reqs++;
      #1;
      if (aux_gnt) gnts++;
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if (disp_valid) dvs++;
      if (aux_valid) avs++;
      if (disp_valid && aux_valid) both++;
      step();
    end
    check("rand_both_valid", both, 0);
    check("rand_disp_accounting", dvs + int'(disp_miss_cnt), reqs);
    check("rand_aux_accounting", avs, gnts);
    check("rand_miss_unsat", disp_miss_cnt < 8'hFF, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
